// File: rtl/wb_multi.sv
// Multi-channel writeback buffer: merges NUM_CH result ports into one register-file write port.
// Define WB_MULTI_BYPASS_EN to let channel 0 skip an empty, unstalled buffer.
module wb_multi #(
    parameter int ADDR_LEN  = 5,
    parameter int WORD_SIZE = 32,
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             valid_i,
    output logic [NUM_CH-1:0]             ready_o,
    input  logic [NUM_CH*ADDR_LEN-1:0]    dst_addr_i,
    input  logic [NUM_CH*WORD_SIZE-1:0]   data_i,
    input  logic                          stall_i,
    output logic [ADDR_LEN-1:0]           dst_addr_o,
    output logic [WORD_SIZE-1:0]          data_o,
    output logic                          w_en,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_LEN-1:0]  addr_mem [DEPTH];
    logic [WORD_SIZE-1:0] data_mem [DEPTH];

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     n_push;
    logic [NUM_CH-1:0] push;
    logic [PW-1:0]     wr_idx [NUM_CH];
    logic              pop;
    logic              byp;

    assign count_o = count;
    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign pop     = !stall_i && (count != '0);

`ifdef WB_MULTI_BYPASS_EN
    assign byp = valid_i[0] && ready_o[0] && (dst_addr_i[ADDR_LEN-1:0] != '0)
               && (count == '0) && !stall_i;
`else
    assign byp = 1'b0;
`endif

    // Credit is based on current occupancy only, so a pop never frees a slot early.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ready_o[i] = (CW'(DEPTH) - count) > CW'(i);
        end
    end

    // Accepted channels pack into consecutive slots in ascending channel order.
    always_comb begin
        n_push = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            push[i]   = valid_i[i] && ready_o[i]
                      && (dst_addr_i[i*ADDR_LEN +: ADDR_LEN] != '0)
                      && !(i == 0 && byp);
            wr_idx[i] = wr_ptr + n_push[PW-1:0];
            if (push[i]) n_push = n_push + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                addr_mem[wr_idx[i]] <= dst_addr_i[i*ADDR_LEN +: ADDR_LEN];
                data_mem[wr_idx[i]] <= data_i[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            w_en       <= 1'b0;
            dst_addr_o <= '0;
            data_o     <= '0;
        end else begin
            count  <= count + n_push - CW'(pop);
            wr_ptr <= wr_ptr + n_push[PW-1:0];
            if (pop) begin
                dst_addr_o <= addr_mem[rd_ptr];
                data_o     <= data_mem[rd_ptr];
                w_en       <= 1'b1;
                rd_ptr     <= rd_ptr + PW'(1);
            end else if (byp) begin
                dst_addr_o <= dst_addr_i[ADDR_LEN-1:0];
                data_o     <= data_i[WORD_SIZE-1:0];
                w_en       <= 1'b1;
            end else begin
                w_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_multi.sv
// Scoreboard bench for wb_multi: stimulus queues expected writes, a negedge
// monitor checks every register-file write against them in order.
module tb_wb_multi;

    logic        clk;
    logic        rst_n;
    logic [1:0]  valid_i;
    logic [1:0]  ready_o;
    logic [9:0]  dst_addr_i;
    logic [63:0] data_i;
    logic        stall_i;
    logic [4:0]  dst_addr_o;
    logic [31:0] data_o;
    logic        w_en;
    logic [2:0]  count_o;
    logic        full_o;
    logic        empty_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] exp_q [$];

    wb_multi dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .dst_addr_i (dst_addr_i),
        .data_i     (data_i),
        .stall_i    (stall_i),
        .dst_addr_o (dst_addr_o),
        .data_o     (data_o),
        .w_en       (w_en),
        .count_o    (count_o),
        .full_o     (full_o),
        .empty_o    (empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] v,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
        valid_i    = v;
        dst_addr_i = {a1, a0};
        data_i     = {d1, d0};
    endtask

    task automatic idle();
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    endtask

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && w_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data %0h want none",
                         dst_addr_o, data_o);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({dst_addr_o, data_o} !== e) begin
                    n_bad++;
                    $display("FAIL write_order: got %0d/%0h want %0d/%0h",
                             dst_addr_o, data_o, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        stall_i = 1'b0;
        idle();
        cyc();
        cyc();
        chk("rst_count", count_o, 0);
        chk("rst_w_en", w_en, 0);
        chk("rst_addr", dst_addr_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        rst_n = 1'b1;
        cyc();
        chk("ready_after_rst", ready_o, 2'b11);

        // Single write through the buffer
        drv(2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'd0);
        exp_q.push_back({5'd3, 32'hDEADBEEF});
        cyc();
        idle();
`ifndef WB_MULTI_BYPASS_EN
        chk("lat_count_k", count_o, 1);
        chk("lat_w_en_k", w_en, 0);
        cyc();
`endif
        chk("lat_w_en", w_en, 1);
        chk("lat_addr", dst_addr_o, 3);
        chk("lat_data", data_o, 32'hDEADBEEF);
        cyc();
        chk("single_pulse", w_en, 0);

        // Two channels in one edge drain in channel order
        drv(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
        exp_q.push_back({5'd1, 32'h11});
        exp_q.push_back({5'd2, 32'h22});
        cyc();
        idle();
        repeat (3) cyc();
        chk("dual_empty", empty_o, 1);

        // Fill under stall, then drain
        stall_i = 1'b1;
        drv(2'b11, 5'd4, 32'h44, 5'd5, 32'h55);
        exp_q.push_back({5'd4, 32'h44});
        exp_q.push_back({5'd5, 32'h55});
        cyc();
        drv(2'b11, 5'd6, 32'h66, 5'd7, 32'h77);
        exp_q.push_back({5'd6, 32'h66});
        exp_q.push_back({5'd7, 32'h77});
        cyc();
        idle();
        chk("full_flag", full_o, 1);
        chk("full_ready", ready_o, 2'b00);
        chk("full_count", count_o, 4);
        chk("full_w_en", w_en, 0);
        cyc();
        cyc();
        chk("stall_w_en", w_en, 0);
        chk("stall_count", count_o, 4);
        stall_i = 1'b0;
        cyc();
        chk("drain_count3", count_o, 3);
        chk("drain_ready3", ready_o, 2'b01);
        repeat (3) cyc();
        chk("drain_empty", empty_o, 1);

        // Address zero is consumed silently
        drv(2'b01, 5'd0, 32'h55, 5'd0, 32'd0);
        cyc();
        idle();
        chk("zero_count", count_o, 0);
        cyc();
        chk("zero_w_en", w_en, 0);

        // Reset with entries buffered discards them
        stall_i = 1'b1;
        drv(2'b11, 5'd8, 32'h88, 5'd9, 32'h99);
        cyc();
        drv(2'b01, 5'd10, 32'hAA, 5'd0, 32'd0);
        cyc();
        idle();
        chk("pre_rst_count", count_o, 3);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_w_en", w_en, 0);
        rst_n   = 1'b1;
        stall_i = 1'b0;
        cyc();
        chk("post_rst_ready", ready_o, 2'b11);
        repeat (3) cyc();
        chk("post_rst_empty", empty_o, 1);

`ifdef WB_MULTI_BYPASS_EN
        drv(2'b01, 5'd7, 32'h77, 5'd0, 32'd0);
        exp_q.push_back({5'd7, 32'h77});
        cyc();
        idle();
        chk("byp_w_en", w_en, 1);
        chk("byp_addr", dst_addr_o, 7);
        chk("byp_count", count_o, 0);
        cyc();
`endif

        // Streaming push/pop with pointer wrap
        for (int k = 0; k < 6; k++) begin
            drv(2'b01, 5'(11 + k), 32'h100 + 32'(k), 5'd0, 32'd0);
            exp_q.push_back({5'(11 + k), 32'h100 + 32'(k)});
            cyc();
        end
        idle();
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) cyc();
        cyc();
        chk("drain_done", 64'(exp_q.size()), 0);
        chk("final_empty", empty_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
